// File: rtl/xor_monitor_pkg.sv
// rtl/xor_monitor_pkg.sv - shared state encoding and default parameters for xor_mismatch_monitor
package xor_monitor_pkg;

    localparam int ALARM_RUN_DEF = 4;
    localparam int CLEAR_RUN_DEF = 2;
    localparam int RUN_W_DEF     = 8;
    localparam int MATCH_W       = 8;
    localparam int EVENT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_ALARM   = 2'd2,
        ST_RECOVER = 2'd3
    } mon_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with sync clear and enable; clr with en loads 1
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // clear has priority; clr together with en restarts the count at 1
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= en_i ? W'(1) : '0;
        end else if (en_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/xor_mismatch_monitor.sv
// rtl/xor_mismatch_monitor.sv - mismatch run monitor with alarm hysteresis; optional XOR_MISMATCH_MONITOR_EVENT_CNT_EN adds event_cnt
module xor_mismatch_monitor
    import xor_monitor_pkg::*;
#(
    parameter int ALARM_RUN = ALARM_RUN_DEF,
    parameter int CLEAR_RUN = CLEAR_RUN_DEF,
    parameter int RUN_W     = RUN_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               diff_valid,
    input  logic               diff,
    output logic               alarm,
    output logic [RUN_W-1:0]   run_len,
`ifdef XOR_MISMATCH_MONITOR_EVENT_CNT_EN
    output logic [EVENT_W-1:0] event_cnt,
`endif
    output logic               alarm_rise
);

    mon_state_e         state_q, state_d;
    logic               alarm_q, rise_q, rise_d;
    logic               run_clr, run_en, mcnt_clr, mcnt_en;
    logic [MATCH_W-1:0] mcnt;
    logic               run_hits_alarm, mcnt_hits_clear;

    sat_counter #(.W(RUN_W)) u_run_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (run_clr),
        .en_i    (run_en),
        .count_o (run_len)
    );

    sat_counter #(.W(MATCH_W)) u_match_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (mcnt_clr),
        .en_i    (mcnt_en),
        .count_o (mcnt)
    );

    // thresholds are checked against the value the counter is about to take
    assign run_hits_alarm  = (({1'b0, run_len} + (RUN_W+1)'(1)) == (RUN_W+1)'(ALARM_RUN));
    assign mcnt_hits_clear = (({1'b0, mcnt} + (MATCH_W+1)'(1)) == (MATCH_W+1)'(CLEAR_RUN));

    // next state, counter controls and rise pulse; invalid cycles hold everything
    always_comb begin
        state_d  = state_q;
        run_clr  = 1'b0;
        run_en   = 1'b0;
        mcnt_clr = 1'b0;
        mcnt_en  = 1'b0;
        rise_d   = 1'b0;
        if (diff_valid) begin
            case (state_q)
                ST_IDLE: begin
                    run_clr = 1'b1;
                    if (diff) begin
                        run_en = 1'b1;
                        if (ALARM_RUN == 1) begin
                            state_d = ST_ALARM;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (diff) begin
                        run_en = 1'b1;
                        if (run_hits_alarm) begin
                            state_d = ST_ALARM;
                            rise_d  = 1'b1;
                        end
                    end else begin
                        run_clr = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_ALARM: begin
                    if (diff) begin
                        run_en = 1'b1;
                    end else begin
                        run_clr  = 1'b1;
                        mcnt_clr = 1'b1;
                        if (CLEAR_RUN == 1) begin
                            state_d = ST_IDLE;
                        end else begin
                            mcnt_en = 1'b1;
                            state_d = ST_RECOVER;
                        end
                    end
                end
                ST_RECOVER: begin
                    if (diff) begin
                        // relapse into alarm is a continuation, not a new event
                        run_clr  = 1'b1;
                        run_en   = 1'b1;
                        mcnt_clr = 1'b1;
                        state_d  = ST_ALARM;
                    end else if (mcnt_hits_clear) begin
                        mcnt_clr = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        mcnt_en = 1'b1;
                    end
                end
                default: begin
                    run_clr  = 1'b1;
                    mcnt_clr = 1'b1;
                    state_d  = ST_IDLE;
                end
            endcase
        end
    end

    // state and registered flag outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            alarm_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            alarm_q <= (state_d == ST_ALARM) || (state_d == ST_RECOVER);
            rise_q  <= rise_d;
        end
    end

    assign alarm      = alarm_q;
    assign alarm_rise = rise_q;

`ifdef XOR_MISMATCH_MONITOR_EVENT_CNT_EN
    logic [EVENT_W-1:0] event_cnt_q;

    // alarm episode counter, wraps naturally at full scale
    always_ff @(posedge clk) begin
        if (reset) begin
            event_cnt_q <= '0;
        end else if (rise_d) begin
            event_cnt_q <= event_cnt_q + EVENT_W'(1);
        end
    end

    assign event_cnt = event_cnt_q;
`endif

endmodule

// File: tb/tb_xor_mismatch_monitor.sv
// tb/tb_xor_mismatch_monitor.sv - directed self-checking bench for xor_mismatch_monitor
module tb_xor_mismatch_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       diff_valid = 1'b0;
    logic       diff = 1'b0;
    logic       alarm1, rise1, alarm2, rise2;
    logic [7:0] run_len1;
    logic [2:0] run_len2;
`ifdef XOR_MISMATCH_MONITOR_EVENT_CNT_EN
    logic [15:0] event_cnt1, event_cnt2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xor_mismatch_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .diff_valid (diff_valid),
        .diff       (diff),
        .alarm      (alarm1),
        .run_len    (run_len1),
`ifdef XOR_MISMATCH_MONITOR_EVENT_CNT_EN
        .event_cnt  (event_cnt1),
`endif
        .alarm_rise (rise1)
    );

    xor_mismatch_monitor #(.ALARM_RUN(4), .CLEAR_RUN(2), .RUN_W(3)) dut_w3 (
        .clk        (clk),
        .reset      (reset),
        .diff_valid (diff_valid),
        .diff       (diff),
        .alarm      (alarm2),
        .run_len    (run_len2),
`ifdef XOR_MISMATCH_MONITOR_EVENT_CNT_EN
        .event_cnt  (event_cnt2),
`endif
        .alarm_rise (rise2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // drive one sample away from the edge, then settle just past the sampling edge
    task automatic step(input logic v, input logic d);
        @(negedge clk);
        diff_valid = v;
        diff = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic a, input logic [7:0] rl, input logic r);
        chk({tag, ".alarm"}, 32'(alarm1), 32'(a));
        chk({tag, ".run_len"}, 32'(run_len1), 32'(rl));
        chk({tag, ".rise"}, 32'(rise1), 32'(r));
    endtask

    initial begin
        logic [7:0] pat_rl [7];
        logic       pat_d  [7];
        pat_d  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        pat_rl = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};

        // reset held two cycles with mismatch on the inputs
        reset = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk_main("reset", 1'b0, 8'd0, 1'b0);
`ifdef XOR_MISMATCH_MONITOR_EVENT_CNT_EN
        chk("reset.event_cnt", 32'(event_cnt1), 32'd0);
`endif
        reset = 1'b0;

        // four mismatches raise the alarm on the fourth
        step(1'b1, 1'b1); chk_main("run1", 1'b0, 8'd1, 1'b0);
        step(1'b1, 1'b1); chk_main("run2", 1'b0, 8'd2, 1'b0);
        step(1'b1, 1'b1); chk_main("run3", 1'b0, 8'd3, 1'b0);
        step(1'b1, 1'b1); chk_main("run4", 1'b1, 8'd4, 1'b1);
        step(1'b0, 1'b0); chk_main("alarm_hold", 1'b1, 8'd4, 1'b0);

        // recovery sequence 0,1,0,0 with no second rise
        step(1'b1, 1'b0); chk_main("rec0", 1'b1, 8'd0, 1'b0);
        step(1'b1, 1'b1); chk_main("rec1", 1'b1, 8'd1, 1'b0);
        step(1'b1, 1'b0); chk_main("rec2", 1'b1, 8'd0, 1'b0);
        step(1'b1, 1'b0); chk_main("rec3", 1'b0, 8'd0, 1'b0);
`ifdef XOR_MISMATCH_MONITOR_EVENT_CNT_EN
        chk("rec.event_cnt", 32'(event_cnt1), 32'd1);
`endif

        // broken runs never reach the alarm
        for (int i = 0; i < 7; i++) begin
            step(1'b1, pat_d[i]);
            chk_main($sformatf("brk%0d", i), 1'b0, pat_rl[i], 1'b0);
        end
        step(1'b1, 1'b0); chk_main("brk_clr", 1'b0, 8'd0, 1'b0);

        // invalid cycles with diff=1 hold a run of 2
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            chk_main($sformatf("inv%0d", i), 1'b0, 8'd2, 1'b0);
        end
        step(1'b1, 1'b1); chk_main("inv_run3", 1'b0, 8'd3, 1'b0);
        step(1'b1, 1'b1); chk_main("inv_run4", 1'b1, 8'd4, 1'b1);
`ifdef XOR_MISMATCH_MONITOR_EVENT_CNT_EN
        chk("inv.event_cnt", 32'(event_cnt1), 32'd2);
`endif

        // reset during recover wins over a valid mismatch
        step(1'b1, 1'b0); chk_main("pre_rst", 1'b1, 8'd0, 1'b0);
        reset = 1'b1;
        step(1'b1, 1'b1); chk_main("rst_rec", 1'b0, 8'd0, 1'b0);
`ifdef XOR_MISMATCH_MONITOR_EVENT_CNT_EN
        chk("rst_rec.event_cnt", 32'(event_cnt1), 32'd0);
`endif
        reset = 1'b0;
        step(1'b1, 1'b1); chk_main("post_rst", 1'b0, 8'd1, 1'b0);

        // narrow counter saturates at 7 while the alarm stays up
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b1);
            chk($sformatf("sat%0d.run_len", i), 32'(run_len2), (i > 7) ? 32'd7 : 32'(i));
            chk($sformatf("sat%0d.alarm", i), 32'(alarm2), (i >= 4) ? 32'd1 : 32'd0);
            chk($sformatf("sat%0d.rise", i), 32'(rise2), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("sat.wide_run_len", 32'(run_len1), 32'd12);

        // two further episodes on the narrow instance
        for (int e = 0; e < 2; e++) begin
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            chk($sformatf("ep%0d.cleared", e), 32'(alarm2), 32'd0);
            for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
            chk($sformatf("ep%0d.rise", e), 32'(rise2), 32'd1);
        end
`ifdef XOR_MISMATCH_MONITOR_EVENT_CNT_EN
        chk("ep.event_cnt", 32'(event_cnt2), 32'd3);
`endif
        step(1'b1, 1'b1);
        chk("ep.rise_one_cycle", 32'(rise2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_mismatch_monitor.md
XOR_MISMATCH_MONITOR -- requirements
Module: xor_mismatch_monitor

Interface
REQ-001 The block SHALL take parameter ALARM_RUN, default 4, the number of consecutive valid mismatches that raises the alarm (legal range 1..2^RUN_W-1).
REQ-002 The block SHALL take parameter CLEAR_RUN, default 2, the number of consecutive valid matches that clears the alarm (legal range 1..255).
REQ-003 The block SHALL take parameter RUN_W, default 8, the width of run_len.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 diff_valid  input  1  qualifies diff; diff is ignored when low.
REQ-007 diff  input  1  XOR mismatch bit from the upstream a^b stage (1 = mismatch).
REQ-008 alarm  output  1  registered; high while a sustained mismatch is in progress.
REQ-009 run_len  output  RUN_W  registered count of current consecutive valid mismatches.
REQ-010 alarm_rise  output  1  registered one-cycle pulse on every alarm 0->1 transition.

Function
REQ-011 The state machine SHALL have states IDLE, RUN, ALARM and RECOVER.
REQ-012 Cycles with diff_valid=0 SHALL hold state, run_len, the match counter and alarm, and SHALL drive alarm_rise=0.
REQ-013 IDLE: valid 1 -> RUN with run_len=1, or -> ALARM directly when ALARM_RUN=1; valid 0 -> stay in IDLE with run_len=0.
REQ-014 RUN: valid 1 -> increment run_len, and go to ALARM when the new value equals ALARM_RUN; valid 0 -> IDLE with run_len=0.
REQ-015 ALARM: valid 1 -> stay, saturating-increment run_len; valid 0 -> RECOVER with run_len=0 and match counter=1, or -> IDLE when CLEAR_RUN=1.
REQ-016 RECOVER: valid 0 -> increment match counter, and go to IDLE when it reaches CLEAR_RUN; valid 1 -> ALARM with run_len=1 and match counter cleared, with no alarm_rise pulse.
REQ-017 alarm SHALL be high exactly in states ALARM and RECOVER; all outputs SHALL appear one cycle after the sampling edge.
REQ-018 run_len SHALL saturate at 2^RUN_W-1 and never wrap.
REQ-019 alarm_rise SHALL pulse only on entry to ALARM from IDLE or RUN.

Reset
REQ-020 reset SHALL force state IDLE, alarm=0, run_len=0, match counter=0, alarm_rise=0 and event_cnt=0 on the next edge.
REQ-021 reset SHALL take priority over diff_valid, including when reset is asserted mid-run or mid-alarm.

Configuration
REQ-022 When XOR_MISMATCH_MONITOR_EVENT_CNT_EN is defined, the block SHALL add output event_cnt (16 bits, registered), incremented with each alarm_rise and wrapping from 0xFFFF to 0.
REQ-023 When XOR_MISMATCH_MONITOR_EVENT_CNT_EN is undefined, event_cnt and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-024 Package xor_monitor_pkg SHALL hold the state enum and the default values of ALARM_RUN, CLEAR_RUN and RUN_W.
REQ-025 Sub-module sat_counter (parameterised width, sync clear, enable, saturating increment) SHALL implement run_len and the match counter.

Verification
REQ-026 reset held 2 cycles, then valid diff=1,1,1,1 -> alarm=1 and alarm_rise pulses one cycle after the 4th sample; run_len=4.
REQ-027 valid 1,1,1,0,1,1,1 -> alarm stays 0; run_len goes 1,2,3,0,1,2,3.
REQ-028 In ALARM, valid 0,1,0,0 -> alarm stays 1 through the 0,1; it falls one cycle after the final 0; no second alarm_rise.
REQ-029 diff_valid=0 with diff=1 for 10 cycles during RUN with run_len=2 -> run_len holds at 2 and alarm stays 0.
REQ-030 RUN_W=3 with 12 valid 1s -> run_len saturates at 7 and alarm stays 1; with the macro defined, 3 separate alarm episodes -> event_cnt=3.
REQ-031 reset asserted during RECOVER -> next cycle alarm=0, run_len=0, and an immediate valid 1 yields RUN with run_len=1.
